// File: rtl/mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and helpers for the byte-serial memory controller.
//   ls_size_e   : load/store access size encoding (byte, half, word)
//   state_e     : controller FSM states
//   IO_SEL      : value of addr[17:16] that selects the memory-mapped IO space
//   byte_count(): number of byte cycles for a given access size
// ----------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } ls_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10
    } state_e;

    localparam logic [1:0] IO_SEL = 2'b11;

    // The unused encoding 2'b11 is treated as a full word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// ----------------------------------------------------------------------------
// mem_ctrl_arb
// Two-way request arbiter between instruction fetch and load/store.
// A port whose done pulse is high this cycle is masked, because its requester
// only drops the level request in the following cycle.
// Build option: MEM_CTRL_RR_ARB_EN selects round-robin (the port not served
// last wins a conflict); without it LS has fixed priority over IF.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_accept      : a grant is being taken this cycle (updates RR history)
//   i_if_req      : fetch request level
//   i_ls_req      : load/store request level
//   i_if_mask     : fetch done pulse this cycle
//   i_ls_mask     : load/store done pulse this cycle
//   o_grant_if    : fetch wins
//   o_grant_ls    : load/store wins
// ----------------------------------------------------------------------------
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_accept,
    input  logic i_if_req,
    input  logic i_ls_req,
    input  logic i_if_mask,
    input  logic i_ls_mask,
    output logic o_grant_if,
    output logic o_grant_ls
);

    logic w_if_req;
    logic w_ls_req;

    assign w_if_req = i_if_req && !i_if_mask;
    assign w_ls_req = i_ls_req && !i_ls_mask;

`ifdef MEM_CTRL_RR_ARB_EN
    // Starts as "IF served last" so the very first conflict goes to LS.
    logic r_last_ls;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_ls <= 1'b0;
        end else if (i_accept) begin
            r_last_ls <= o_grant_ls;
        end
    end

    assign o_grant_ls = w_ls_req && (!w_if_req || !r_last_ls);
    assign o_grant_if = w_if_req && !o_grant_ls;
`else
    logic w_unused_rr;
    assign w_unused_rr = i_clk ^ i_rst ^ i_accept;

    assign o_grant_ls = w_ls_req;
    assign o_grant_if = w_if_req && !w_ls_req;
`endif

endmodule

// File: rtl/mem_ctrl.sv
// ----------------------------------------------------------------------------
// mem_ctrl
// Byte-serial memory controller sharing one 8-bit RAM/IO port between
// instruction fetch (IF) and the load/store unit (LS). Accesses of 1/2/4
// bytes are split into byte cycles; reads assemble little-endian words,
// zero-extended. Honours the 1-cycle RAM read latency, UART TX back-pressure,
// the rdy_in pause and pipeline flush.
// Build option: MEM_CTRL_RR_ARB_EN (round-robin arbitration, see mem_ctrl_arb).
// Ports:
//   clk_in, rst_in       : clock, synchronous active-high reset
//   rdy_in               : low = pause, all state frozen, no writes
//   clear_in             : pipeline flush
//   if_req/if_addr       : fetch request (always a 4-byte read)
//   if_done/if_data      : fetch completion pulse and word
//   ls_req/ls_we/ls_size/ls_addr/ls_wdata : load/store request
//   ls_done/ls_rdata     : load/store completion pulse and load data
//   mem_din/mem_dout/mem_a/mem_wr : external byte bus
//   io_buffer_full       : UART TX buffer full, stalls IO writes
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | bus quiet (mem_a=0), arbitrating and latching the next request
// ST_READ  | issuing byte addresses and capturing bytes one cycle later
// ST_WRITE | writing one byte per cycle, holding while IO buffer is full
// ----------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [1:0]            ls_size,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    state_e                r_state,    w_state_n;
    logic [ADDR_WIDTH-1:0] r_base,     w_base_n;
    logic [2:0]            r_n,        w_n_n;
    logic [2:0]            r_iptr,     w_iptr_n;
    logic [2:0]            r_cptr,     w_cptr_n;
    logic                  r_cap_vld,  w_cap_vld_n;
    logic [31:0]           r_wdata,    w_wdata_n;
    logic [31:0]           r_buf,      w_buf_n;
    logic                  r_owner_ls, w_owner_ls_n;
    logic                  r_if_done,  w_if_done_n;
    logic                  r_ls_done,  w_ls_done_n;
    logic [31:0]           r_if_data,  w_if_data_n;
    logic [31:0]           r_ls_rdata, w_ls_rdata_n;
    // rdy_in of the previous cycle; keeps updating during a pause so the
    // first cycle after resume can be recognised.
    logic                  r_rdy_q;

    logic                  w_grant_if;
    logic                  w_grant_ls;
    logic                  w_accept;
    logic                  w_replay;
    logic                  w_rd_issue;
    logic [2:0]            w_ptr;
    logic [ADDR_WIDTH-1:0] w_cur_addr;
    logic                  w_io;
    logic                  w_wr_go;
    logic [7:0]            w_wr_byte;
    logic [31:0]           w_buf_ins;

    mem_ctrl_arb u_arb (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_accept   (w_accept),
        .i_if_req   (if_req),
        .i_ls_req   (ls_req),
        .i_if_mask  (r_if_done),
        .i_ls_mask  (r_ls_done),
        .o_grant_if (w_grant_if),
        .o_grant_ls (w_grant_ls)
    );

    assign w_accept = (r_state == ST_IDLE) && !clear_in && rdy_in &&
                      (w_grant_if || w_grant_ls);

    // After a pause the byte in flight was lost (its data came back while
    // frozen), so the oldest uncaptured address is reissued before normal
    // issue resumes.
    assign w_replay   = (r_state == ST_READ) && !r_rdy_q;
    assign w_rd_issue = (r_state == ST_READ) && !w_replay && (r_iptr < r_n);
    assign w_ptr      = w_replay ? r_cptr : r_iptr;
    assign w_cur_addr = r_base + {{(ADDR_WIDTH-3){1'b0}}, w_ptr};
    assign w_io       = (w_cur_addr[17:16] == IO_SEL);
    assign w_wr_go    = (r_state == ST_WRITE) && !(w_io && io_buffer_full);
    assign w_wr_byte  = r_wdata[{r_iptr[1:0], 3'b000} +: 8];

    assign mem_a    = ((r_state == ST_WRITE) || w_rd_issue || w_replay) ? w_cur_addr : '0;
    assign mem_dout = (r_state == ST_WRITE) ? w_wr_byte : 8'h00;
    assign mem_wr   = w_wr_go && rdy_in;

    assign if_done  = r_if_done;
    assign if_data  = r_if_data;
    assign ls_done  = r_ls_done;
    assign ls_rdata = r_ls_rdata;

    always_comb begin
        w_buf_ins = r_buf;
        w_buf_ins[{r_cptr[1:0], 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        w_state_n    = r_state;
        w_base_n     = r_base;
        w_n_n        = r_n;
        w_iptr_n     = r_iptr;
        w_cptr_n     = r_cptr;
        w_cap_vld_n  = r_cap_vld;
        w_wdata_n    = r_wdata;
        w_buf_n      = r_buf;
        w_owner_ls_n = r_owner_ls;
        w_if_done_n  = 1'b0;
        w_ls_done_n  = 1'b0;
        w_if_data_n  = r_if_data;
        w_ls_rdata_n = r_ls_rdata;

        case (r_state)
            ST_IDLE: begin
                if (!clear_in && (w_grant_ls || w_grant_if)) begin
                    w_iptr_n     = 3'd0;
                    w_cptr_n     = 3'd0;
                    w_cap_vld_n  = 1'b0;
                    w_buf_n      = 32'h0;
                    w_owner_ls_n = w_grant_ls;
                    if (w_grant_ls) begin
                        w_base_n  = ls_addr;
                        w_n_n     = byte_count(ls_size);
                        w_wdata_n = ls_wdata;
                        w_state_n = ls_we ? ST_WRITE : ST_READ;
                    end else begin
                        w_base_n  = if_addr;
                        w_n_n     = 3'd4;
                        w_state_n = ST_READ;
                    end
                end
            end

            ST_READ: begin
                if (clear_in) begin
                    w_state_n   = ST_IDLE;
                    w_cap_vld_n = 1'b0;
                end else if (w_replay) begin
                    w_iptr_n    = r_cptr + 3'd1;
                    w_cap_vld_n = 1'b1;
                end else begin
                    w_iptr_n    = w_rd_issue ? (r_iptr + 3'd1) : r_iptr;
                    w_cap_vld_n = w_rd_issue;
                    if (r_cap_vld) begin
                        w_buf_n  = w_buf_ins;
                        w_cptr_n = r_cptr + 3'd1;
                        if (r_cptr == (r_n - 3'd1)) begin
                            w_state_n   = ST_IDLE;
                            w_cap_vld_n = 1'b0;
                            if (r_owner_ls) begin
                                w_ls_done_n  = 1'b1;
                                w_ls_rdata_n = w_buf_ins;
                            end else begin
                                w_if_done_n  = 1'b1;
                                w_if_data_n  = w_buf_ins;
                            end
                        end
                    end
                end
            end

            ST_WRITE: begin
                // Stores already on the bus are not flushed by clear_in.
                if (w_wr_go) begin
                    w_iptr_n = r_iptr + 3'd1;
                    if (r_iptr == (r_n - 3'd1)) begin
                        w_state_n   = ST_IDLE;
                        w_ls_done_n = 1'b1;
                    end
                end
            end

            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_base     <= '0;
            r_n        <= 3'd0;
            r_iptr     <= 3'd0;
            r_cptr     <= 3'd0;
            r_cap_vld  <= 1'b0;
            r_wdata    <= 32'h0;
            r_buf      <= 32'h0;
            r_owner_ls <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_data  <= 32'h0;
            r_ls_rdata <= 32'h0;
            r_rdy_q    <= 1'b1;
        end else begin
            r_rdy_q <= rdy_in;
            if (rdy_in) begin
                r_state    <= w_state_n;
                r_base     <= w_base_n;
                r_n        <= w_n_n;
                r_iptr     <= w_iptr_n;
                r_cptr     <= w_cptr_n;
                r_cap_vld  <= w_cap_vld_n;
                r_wdata    <= w_wdata_n;
                r_buf      <= w_buf_n;
                r_owner_ls <= w_owner_ls_n;
                r_if_done  <= w_if_done_n;
                r_ls_done  <= w_ls_done_n;
                r_if_data  <= w_if_data_n;
                r_ls_rdata <= w_ls_rdata_n;
            end
        end
    end

endmodule
